// File: rtl/dispatcher_pkg.sv
// Shared types and sizing constants for the thread dispatcher lane scanners.
// Holds the unrolling-factor encoding and the scanner state type.
package dispatcher_pkg;

    localparam int LANE_BITS  = 64;
    localparam int CHUNK_BITS = 256;
    localparam int NUM_LANES  = 4;
    localparam int POS_BITS   = 6;
    localparam int COUNT_BITS = 7;

    // Encoding 2'd3 is deliberately absent: it is the illegal factor.
    typedef enum logic [1:0] {
        UF_1 = 2'd0,
        UF_2 = 2'd1,
        UF_4 = 2'd2
    } uf_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/lsb_priority_encoder64.sv
// Combinational find-first-set: index of the lowest set bit of a 64-bit vector.
// The index is 0 when no bit is set.
module lsb_priority_encoder64
    import dispatcher_pkg::*;
(
    input  logic [LANE_BITS-1:0] vec,
    output logic [POS_BITS-1:0]  index,
    output logic                 any_set
);

    // Scanning from the top lets the lowest set bit overwrite last.
    always_comb begin
        index   = '0;
        any_set = |vec;
        for (int i = LANE_BITS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = POS_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/lane_thread_scanner.sv
// Extracts one lane's 64-bit slice of a 256-bit active mask and emits the
// positions of its active threads, lowest first, over a valid/ready port.
module lane_thread_scanner
    import dispatcher_pkg::*;
#(
    parameter int UNROLLING_INDEX = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [CHUNK_BITS-1:0]  active_mask,
    input  logic [1:0]             unrolling_factor,
    input  logic                   flush,
    output logic                   pos_valid,
    input  logic                   pos_ready,
    output logic [POS_BITS-1:0]    encoded_pos,
    output logic [COUNT_BITS-1:0]  emitted_count,
    output logic                   done,
    output logic                   bad_uf
);

    localparam int L    = UNROLLING_INDEX % NUM_LANES;
    localparam int L_HI = L / 2;
    localparam int L_LO = L % 2;

    state_e                 state_reg, state_next;
    logic [LANE_BITS-1:0]   vec_reg, vec_next;
    logic [COUNT_BITS-1:0]  count_reg, count_next;
    logic                   bad_reg, bad_next;

    logic [LANE_BITS-1:0]   gather_x1, gather_x2, gather_x4, gathered;
    logic [LANE_BITS-1:0]   clear_mask, remaining;
    logic [POS_BITS-1:0]    lsb_index;
    logic                   lsb_any;

    // Lane slice selection: contiguous for x1, 16-bit interleave for x2,
    // 8-bit interleave for x4.
    for (genvar gi = 0; gi < LANE_BITS; gi++) begin : g_gather
        assign gather_x1[gi] = active_mask[L * LANE_BITS + gi];
        assign gather_x2[gi] = active_mask[L_HI * 128 + (gi / 16) * 32 + L_LO * 16 + (gi % 16)];
        assign gather_x4[gi] = active_mask[(gi / 8) * 32 + L * 8 + (gi % 8)];
    end

    always_comb begin
        case (uf_e'(unrolling_factor))
            UF_1:    gathered = gather_x1;
            UF_2:    gathered = gather_x2;
            UF_4:    gathered = gather_x4;
            default: gathered = '0;
        endcase
    end

    lsb_priority_encoder64 u_encoder (
        .vec     (vec_reg),
        .index   (lsb_index),
        .any_set (lsb_any)
    );

    assign clear_mask = LANE_BITS'(1) << lsb_index;
    assign remaining  = vec_reg & ~clear_mask;

    always_comb begin
        state_next = state_reg;
        vec_next   = vec_reg;
        count_next = count_reg;
        bad_next   = bad_reg;
        if (flush) begin
            state_next = IDLE;
            vec_next   = '0;
            count_next = '0;
            bad_next   = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_valid) begin
                        vec_next   = gathered;
                        count_next = '0;
                        bad_next   = (unrolling_factor == 2'd3);
                        state_next = (gathered != '0) ? SCAN : DONE;
                    end
                end
                SCAN: begin
                    if (pos_ready) begin
                        vec_next   = remaining;
                        count_next = count_reg + COUNT_BITS'(1);
                        if (remaining == '0) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            vec_reg   <= '0;
            count_reg <= '0;
            bad_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            vec_reg   <= vec_next;
            count_reg <= count_next;
            bad_reg   <= bad_next;
        end
    end

    assign load_ready    = (state_reg == IDLE);
    assign pos_valid     = (state_reg == SCAN) && lsb_any;
    assign encoded_pos   = lsb_index;
    assign emitted_count = count_reg;
    assign done          = (state_reg == DONE);
    assign bad_uf        = (state_reg == DONE) && bad_reg;

endmodule

// File: tb/tb_lane_thread_scanner.sv
// Bench for lane_thread_scanner: four instances (one per lane index) share the
// stimulus; each lane has a queue-based scoreboard fed at load time.
module tb_lane_thread_scanner;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_valid = 1'b0;
    logic         flush = 1'b0;
    logic         pos_ready = 1'b0;
    logic [255:0] active_mask = '0;
    logic [1:0]   unrolling_factor = 2'd0;

    logic [3:0]   load_ready, pos_valid, done, bad_uf;
    logic [5:0]   encoded_pos [4];
    logic [6:0]   emitted_count [4];

    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s lane%0d: got %0d, required %0d (t=%0t)", name, lane, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_gather(input logic [255:0] m, input logic [1:0] uf, input logic [1:0] lane);
        logic [63:0] v;
        logic [7:0]  idx;
        logic [5:0]  i6;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            i6 = i[5:0];
            case (uf)
                2'd0:    idx = {lane, i6};
                2'd1:    idx = {lane[1], i6[5:4], lane[0], i6[3:0]};
                2'd2:    idx = {i6[5:3], lane, i6[2:0]};
                default: idx = 8'd0;
            endcase
            v[i] = (uf == 2'd3) ? 1'b0 : m[idx];
        end
        return v;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        lane_thread_scanner #(.UNROLLING_INDEX(gi)) u_dut (
            .clk              (clk),
            .reset            (reset),
            .load_valid       (load_valid),
            .load_ready       (load_ready[gi]),
            .active_mask      (active_mask),
            .unrolling_factor (unrolling_factor),
            .flush            (flush),
            .pos_valid        (pos_valid[gi]),
            .pos_ready        (pos_ready),
            .encoded_pos      (encoded_pos[gi]),
            .emitted_count    (emitted_count[gi]),
            .done             (done[gi]),
            .bad_uf           (bad_uf[gi])
        );

        logic [5:0]  q[$];
        int          mstate = 0;   // 0 idle, 1 scan, 2 done
        int          mcount = 0;
        bit          mbad = 1'b0;
        logic [63:0] mv;

        initial begin : monitor
            forever begin
                @(negedge clk);
                if (reset) begin
                    q.delete();
                    mstate = 0;
                    mcount = 0;
                    mbad   = 1'b0;
                end
                check("load_ready", gi, 32'(load_ready[gi]), 32'(mstate == 0));
                check("pos_valid", gi, 32'(pos_valid[gi]), 32'(mstate == 1));
                check("done", gi, 32'(done[gi]), 32'(mstate == 2));
                check("bad_uf", gi, 32'(bad_uf[gi]), 32'(mstate == 2 && mbad));
                check("emitted_count", gi, 32'(emitted_count[gi]), 32'(mcount));
                if (mstate == 1 && q.size() > 0)
                    check("encoded_pos", gi, 32'(encoded_pos[gi]), 32'(q[0]));
                if (!reset) begin
                    if (flush) begin
                        q.delete();
                        mstate = 0;
                        mcount = 0;
                        mbad   = 1'b0;
                    end else if (mstate == 0) begin
                        if (load_valid) begin
                            mv = model_gather(active_mask, unrolling_factor, 2'(gi));
                            q.delete();
                            for (int i = 0; i < 64; i++)
                                if (mv[i]) q.push_back(6'(i));
                            mcount = 0;
                            mbad   = (unrolling_factor == 2'd3);
                            mstate = (mv != '0) ? 1 : 2;
                        end
                    end else if (mstate == 1) begin
                        if (pos_ready && q.size() > 0) begin
                            void'(q.pop_front());
                            mcount++;
                            if (q.size() == 0) mstate = 2;
                        end
                    end else begin
                        mstate = 0;
                    end
                end
            end
        end
    end

    typedef struct packed {
        logic [255:0]    mask;
        logic [1:0]      uf;
        logic [3:0][6:0] cnt;
        logic            bad;
    } vec_t;

    function automatic vec_t mk(input logic [255:0] m, input logic [1:0] uf,
                                input int c0, input int c1, input int c2, input int c3, input bit bad);
        vec_t r;
        r.mask   = m;
        r.uf     = uf;
        r.cnt[0] = 7'(c0);
        r.cnt[1] = 7'(c1);
        r.cnt[2] = 7'(c2);
        r.cnt[3] = 7'(c3);
        r.bad    = bad;
        return r;
    endfunction

    task automatic wait_all_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (load_ready !== 4'hF) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                applied++;
                miscompares++;
                $display("FAIL idle_timeout: load_ready=%b, required 1111", load_ready);
                break;
            end
        end
    endtask

    task automatic do_load(input logic [255:0] m, input logic [1:0] uf);
        @(posedge clk);
        #1;
        active_mask      = m;
        unrolling_factor = uf;
        load_valid       = 1'b1;
        $display("load mask=%h uf=%0d", m, uf);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(256'h8000_0000_0000_0011, 2'd0, 3, 0, 0, 0, 1'b0);
        tbl[1] = mk((256'd1 << 16) | (256'd1 << 112), 2'd1, 0, 2, 0, 0, 1'b0);
        tbl[2] = mk((256'd1 << 24) | (256'd1 << 255), 2'd2, 0, 0, 0, 2, 1'b0);
        tbl[3] = mk({256{1'b1}}, 2'd3, 0, 0, 0, 0, 1'b1);
        tbl[4] = mk({256{1'b1}}, 2'd0, 64, 64, 64, 64, 1'b0);
        tbl[5] = mk(256'd1, 2'd1, 1, 0, 0, 0, 1'b0);
        tbl[6] = mk(256'hFF, 2'd2, 8, 0, 0, 0, 1'b0);
        tbl[7] = mk('0, 2'd0, 0, 0, 0, 0, 1'b0);

        // Reset values while reset is held
        repeat (3) @(posedge clk);
        #1;
        for (int l = 0; l < 4; l++) begin
            check("rst_pos_valid", l, 32'(pos_valid[l]), 0);
            check("rst_done", l, 32'(done[l]), 0);
            check("rst_bad_uf", l, 32'(bad_uf[l]), 0);
            check("rst_count", l, 32'(emitted_count[l]), 0);
            check("rst_encoded_pos", l, 32'(encoded_pos[l]), 0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("rst_load_ready", 0, 32'(load_ready), 32'hF);

        // Table-driven chunks, drained with pos_ready held high
        pos_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            wait_all_idle();
            do_load(tbl[t].mask, tbl[t].uf);
            @(negedge clk);
            if (tbl[t].bad) check("tbl_bad_uf", t, 32'(bad_uf), 32'hF);
            wait_all_idle();
            for (int l = 0; l < 4; l++)
                check("tbl_count", l, 32'(emitted_count[l]), 32'(tbl[t].cnt[l]));
        end

        // Lane 0, bits 0,4,63: positions on consecutive cycles
        wait_all_idle();
        do_load(256'h8000_0000_0000_0011, 2'd0);
        @(negedge clk);
        check("seq0_pos0", 0, 32'(encoded_pos[0]), 0);
        check("seq0_valid0", 0, 32'(pos_valid[0]), 1);
        check("seq0_other_done", 1, 32'(done[1]), 1);
        @(negedge clk);
        check("seq0_pos1", 0, 32'(encoded_pos[0]), 4);
        @(negedge clk);
        check("seq0_pos2", 0, 32'(encoded_pos[0]), 63);
        @(negedge clk);
        check("seq0_done", 0, 32'(done[0]), 1);
        check("seq0_valid_done", 0, 32'(pos_valid[0]), 0);
        check("seq0_count", 0, 32'(emitted_count[0]), 3);

        // Lane 1, x2: bits 16 and 112 map to 0 and 48
        wait_all_idle();
        do_load((256'd1 << 16) | (256'd1 << 112), 2'd1);
        @(negedge clk);
        check("seq1_pos0", 1, 32'(encoded_pos[1]), 0);
        @(negedge clk);
        check("seq1_pos1", 1, 32'(encoded_pos[1]), 48);
        @(negedge clk);
        check("seq1_done", 1, 32'(done[1]), 1);

        // Lane 1, x2: bit 0 belongs to another lane
        wait_all_idle();
        do_load(256'd1, 2'd1);
        @(negedge clk);
        check("empty_done", 1, 32'(done[1]), 1);
        check("empty_valid", 1, 32'(pos_valid[1]), 0);
        check("empty_count", 1, 32'(emitted_count[1]), 0);

        // Lane 3, x4: backpressure keeps encoded_pos stable
        wait_all_idle();
        pos_ready = 1'b0;
        do_load((256'd1 << 24) | (256'd1 << 255), 2'd2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_valid", 3, 32'(pos_valid[3]), 1);
            check("stall_pos", 3, 32'(encoded_pos[3]), 0);
        end
        @(posedge clk);
        #1;
        pos_ready = 1'b1;
        @(negedge clk);
        check("stall_pos_release", 3, 32'(encoded_pos[3]), 0);
        @(negedge clk);
        check("stall_pos_last", 3, 32'(encoded_pos[3]), 63);
        check("stall_count", 3, 32'(emitted_count[3]), 1);

        // Illegal factor: done and bad_uf pulse together, nothing emitted
        wait_all_idle();
        do_load({256{1'b1}}, 2'd3);
        @(negedge clk);
        check("uf3_done", 0, 32'(done), 32'hF);
        check("uf3_bad", 0, 32'(bad_uf), 32'hF);
        check("uf3_valid", 0, 32'(pos_valid), 0);
        @(negedge clk);
        check("uf3_bad_gone", 0, 32'(bad_uf), 0);
        check("uf3_done_gone", 0, 32'(done), 0);

        // Lane 2 flushed after 10 handshakes
        wait_all_idle();
        do_load({64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 128'h0}, 2'd0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_pre_count", 2, 32'(emitted_count[2]), 10);
        check("flush_pre_pos", 2, 32'(encoded_pos[2]), 10);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_ready", 2, 32'(load_ready[2]), 1);
        check("flush_valid", 2, 32'(pos_valid[2]), 0);
        check("flush_count", 2, 32'(emitted_count[2]), 0);
        check("flush_done", 2, 32'(done[2]), 0);
        @(negedge clk);
        check("flush_no_done", 2, 32'(done[2]), 0);

        // Asynchronous reset in the middle of a full scan
        wait_all_idle();
        do_load({256{1'b1}}, 2'd0);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 0, 32'(pos_valid), 0);
        check("arst_ready", 0, 32'(load_ready), 32'hF);
        for (int l = 0; l < 4; l++)
            check("arst_count", l, 32'(emitted_count[l]), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("arst_no_done", 0, 32'(done), 0);
            check("arst_idle", 0, 32'(load_ready), 32'hF);
        end

        wait_all_idle();
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/lane_thread_scanner.md
LANE_THREAD_SCANNER -- requirements
Module: lane_thread_scanner

Interface
REQ-001 SHALL have parameter UNROLLING_INDEX, default 0, meaning the lane index (0-3) whose slice of the 256-bit active mask is scanned.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port load_valid  input  1  a new 256-bit mask chunk is offered.
REQ-005 SHALL have port load_ready  output  1  scanner accepts a chunk this cycle.
REQ-006 SHALL have port active_mask  input  256  active mask chunk, sampled on load handshake.
REQ-007 SHALL have port unrolling_factor  input  2  0=1, 1=2, 2=4, 3=illegal; sampled on load handshake.
REQ-008 SHALL have port flush  input  1  synchronous abort of the current chunk.
REQ-009 SHALL have port pos_valid  output  1  encoded_pos is valid.
REQ-010 SHALL have port pos_ready  input  1  downstream reverse mapper/dispatcher consumes encoded_pos.
REQ-011 SHALL have port encoded_pos  output  6  lane-local position (0-63) of the next active thread.
REQ-012 SHALL have port emitted_count  output  7  number of positions handshaked for the current chunk (0-64).
REQ-013 SHALL have port done  output  1  one-cycle pulse when the chunk is fully drained.
REQ-014 SHALL have port bad_uf  output  1  one-cycle pulse, coincident with done, when the chunk was loaded with unrolling_factor=3.

Function
REQ-015 SHALL implement states IDLE, SCAN, DONE; load_ready=1 only in IDLE.
REQ-016 On load handshake SHALL gather the 64-bit lane vector v: for uf=0, v[i]=mask[{L,i}]; for uf=1, v[i]=mask[{L[1],i[5:4],L[0],i[3:0]}]; for uf=2, v[i]=mask[{i[5:3],L,i[2:0]}], where L=UNROLLING_INDEX.
REQ-017 For uf=3, v SHALL be all zeros and bad_uf SHALL be flagged for the DONE cycle.
REQ-018 IDLE->SCAN on load handshake if v!=0; IDLE->DONE if v==0.
REQ-019 In SCAN, pos_valid SHALL be 1 and encoded_pos SHALL equal the index of the lowest set bit of the registered vector; first pos_valid appears the cycle after the load handshake.
REQ-020 On pos_valid&&pos_ready SHALL clear that bit and increment emitted_count; throughput one position per cycle.
REQ-021 encoded_pos SHALL hold stable while pos_valid=1 and pos_ready=0.
REQ-022 When the handshaked bit is the last set bit, SCAN->DONE; pos_valid=0 in DONE.
REQ-023 DONE SHALL last exactly one cycle (done=1), then return to IDLE; emitted_count holds its value until the next load handshake, where it resets to 0.
REQ-024 flush SHALL take priority over all handshakes: next state IDLE, vector cleared, emitted_count cleared, no done pulse; flush in IDLE has no effect beyond clearing emitted_count.
REQ-025 A full vector (64 bits set) SHALL yield 64 positions 0..63 in ascending order with emitted_count reaching 64.

Reset
REQ-026 On reset assertion, state=IDLE, lane vector=0, emitted_count=0, pos_valid=0, done=0, bad_uf=0, encoded_pos=0, load_ready=1 after release; reset mid-scan SHALL discard remaining positions with no done pulse.

Structure
REQ-027 SHALL place the unrolling-factor enum (UF_1, UF_2, UF_4), the state typedef, and constants LANE_BITS=64, CHUNK_BITS=256, NUM_LANES=4 in shared package dispatcher_pkg.
REQ-028 SHALL instantiate one combinational sub-module lsb_priority_encoder64 (64-bit in, 6-bit index plus any-set out).

Verification
REQ-029 L=0, uf=0, mask=0x...0000_8000_0000_0011 (bits 0,4,63), pos_ready=1 -> positions 0,4,63 on consecutive cycles starting 1 cycle after load, done one cycle later, emitted_count=3.
REQ-030 L=1, uf=1, mask bit 16 and bit 112 set -> positions 0 then 48; mask bit 0 only -> done at load+1, zero positions.
REQ-031 L=3, uf=2, mask bits 24 and 255 set -> positions 0 and 63; pos_ready held low 5 cycles -> encoded_pos stable at 0 throughout.
REQ-032 uf=3, mask all ones -> no pos_valid, done and bad_uf both pulse at load+1.
REQ-033 L=2, uf=0, mask bits 128-191 all set, flush asserted after 10 handshakes -> IDLE next cycle, no done pulse, load_ready=1, emitted_count=0.
REQ-034 Reset asserted asynchronously mid-scan -> pos_valid drops immediately, state IDLE, emitted_count=0, no done pulse.
